// File: rtl/mesi_isc_pkg.sv
// Shared definitions for the MESI intercache coherence controller:
// main-bus command codes, broadcast request types and default widths.
package mesi_isc_pkg;

  localparam int MBUS_CMD_W      = 3;
  localparam int PORT_ID_W       = 2;
  localparam int ADDR_W          = 32;
  localparam int BROAD_TYPE_W    = 2;
  localparam int BROAD_ID_W      = 5;
  localparam int NUM_PORTS_DEF   = 4;

  typedef enum logic [MBUS_CMD_W-1:0] {
    MBUS_NOP      = 3'd0,
    MBUS_WR       = 3'd1,
    MBUS_RD       = 3'd2,
    MBUS_WR_BROAD = 3'd3,
    MBUS_RD_BROAD = 3'd4
  } mbus_cmd_e;

  typedef enum logic [BROAD_TYPE_W-1:0] {
    BREQ_NOP = 2'd0,
    BREQ_WR  = 2'd1,
    BREQ_RD  = 2'd2
  } breq_type_e;

  function automatic logic is_broad(logic [MBUS_CMD_W-1:0] c);
    return (c == MBUS_WR_BROAD) || (c == MBUS_RD_BROAD);
  endfunction

endpackage

// File: rtl/mesi_isc_rr_pick.sv
// Combinational rotating priority picker: first set bit of elig_i found
// scanning upward from ptr_i, wrapping modulo NUM_PORTS.
module mesi_isc_rr_pick #(
  parameter int NUM_PORTS = 4,
  parameter int IDX_W     = 2
) (
  input  logic [NUM_PORTS-1:0] elig_i,
  input  logic [IDX_W-1:0]     ptr_i,
  output logic [NUM_PORTS-1:0] gnt_o,
  output logic [IDX_W-1:0]     gnt_idx_o
);

  int   j;
  logic found;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    j         = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      j = (int'(ptr_i) + i) % NUM_PORTS;
      if (!found && elig_i[j]) begin
        gnt_o[j]  = 1'b1;
        gnt_idx_o = IDX_W'(j);
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mesi_isc_broad_arb.sv
// Round-robin arbiter feeding the single broadcast-request path from four
// main-bus ports, one outstanding broadcast per port, tagged with a rolling ID.
module mesi_isc_broad_arb
  import mesi_isc_pkg::*;
#(
  parameter int NUM_PORTS        = NUM_PORTS_DEF,
  parameter int PORT_ID_WIDTH    = PORT_ID_W,
  parameter int MBUS_CMD_WIDTH   = MBUS_CMD_W,
  parameter int ADDR_WIDTH       = ADDR_W,
  parameter int BROAD_TYPE_WIDTH = BROAD_TYPE_W,
  parameter int BROAD_ID_WIDTH   = BROAD_ID_W
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_PORTS*MBUS_CMD_WIDTH-1:0]  mbus_cmd_i,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]      mbus_addr_i,
  output logic [NUM_PORTS-1:0]                 mbus_ack_o,
  output logic                                 broad_valid_o,
  input  logic                                 broad_ready_i,
  output logic [BROAD_TYPE_WIDTH-1:0]          broad_type_o,
  output logic [PORT_ID_WIDTH-1:0]             broad_cpu_id_o,
  output logic [ADDR_WIDTH-1:0]                broad_addr_o,
  output logic [BROAD_ID_WIDTH-1:0]            broad_id_o,
  input  logic [NUM_PORTS-1:0]                 broad_done_i,
  output logic [NUM_PORTS-1:0]                 port_busy_o,
  output logic                                 illegal_cmd_o
);

  logic [NUM_PORTS-1:0]        elig, bad, gnt;
  logic [PORT_ID_WIDTH-1:0]    gnt_idx;
  logic [MBUS_CMD_WIDTH-1:0]   sel_cmd;
  logic                        load, grant;

  logic [PORT_ID_WIDTH-1:0]    rr_ptr_q, rr_ptr_d;
  logic [BROAD_ID_WIDTH-1:0]   id_cnt_q, id_cnt_d;
  logic [NUM_PORTS-1:0]        busy_q, busy_d;
  logic                        valid_q, valid_d;
  logic [BROAD_TYPE_WIDTH-1:0] type_q, type_d;
  logic [PORT_ID_WIDTH-1:0]    cpu_id_q, cpu_id_d;
  logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
  logic [BROAD_ID_WIDTH-1:0]   id_q, id_d;
  logic                        illegal_q, illegal_d;

  // Gating eligibility with rst_n keeps mbus_ack_o low while in reset.
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [MBUS_CMD_WIDTH-1:0] cmd;
    assign cmd     = mbus_cmd_i[p*MBUS_CMD_WIDTH +: MBUS_CMD_WIDTH];
    assign elig[p] = rst_n && is_broad(cmd) && !busy_q[p];
    assign bad[p]  = cmd > MBUS_RD_BROAD;
  end

  mesi_isc_rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (PORT_ID_WIDTH)
  ) u_pick (
    .elig_i    (elig),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign load       = !valid_q || broad_ready_i;
  assign grant      = load && (|elig);
  assign mbus_ack_o = grant ? gnt : '0;
  assign sel_cmd    = mbus_cmd_i[gnt_idx*MBUS_CMD_WIDTH +: MBUS_CMD_WIDTH];

  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    id_cnt_d  = id_cnt_q;
    busy_d    = busy_q & ~broad_done_i;
    valid_d   = valid_q;
    type_d    = type_q;
    cpu_id_d  = cpu_id_q;
    addr_d    = addr_q;
    id_d      = id_q;
    illegal_d = illegal_q | (|bad);
    if (load) valid_d = grant;
    // Grant is applied after the done-clear so a same-cycle stale done loses.
    if (grant) begin
      busy_d[gnt_idx] = 1'b1;
      rr_ptr_d        = gnt_idx + PORT_ID_WIDTH'(1);
      id_cnt_d        = id_cnt_q + BROAD_ID_WIDTH'(1);
      type_d          = (sel_cmd == MBUS_WR_BROAD) ? BREQ_WR : BREQ_RD;
      cpu_id_d        = gnt_idx;
      addr_d          = mbus_addr_i[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
      id_d            = id_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q  <= '0;
      id_cnt_q  <= '0;
      busy_q    <= '0;
      valid_q   <= 1'b0;
      type_q    <= '0;
      cpu_id_q  <= '0;
      addr_q    <= '0;
      id_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      id_cnt_q  <= id_cnt_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      type_q    <= type_d;
      cpu_id_q  <= cpu_id_d;
      addr_q    <= addr_d;
      id_q      <= id_d;
      illegal_q <= illegal_d;
    end
  end

  assign broad_valid_o  = valid_q;
  assign broad_type_o   = type_q;
  assign broad_cpu_id_o = cpu_id_q;
  assign broad_addr_o   = addr_q;
  assign broad_id_o     = id_q;
  assign port_busy_o    = busy_q;
  assign illegal_cmd_o  = illegal_q;

endmodule

// File: tb/tb_mesi_isc_broad_arb.sv
// Scoreboard bench for mesi_isc_broad_arb: expected payloads are queued as
// stimulus is driven and compared whenever the output handshake completes.
module tb_mesi_isc_broad_arb;

  logic        clk;
  logic        rst_n;
  logic [11:0] mbus_cmd_i;
  logic [127:0] mbus_addr_i;
  logic [3:0]  mbus_ack_o;
  logic        broad_valid_o;
  logic        broad_ready_i;
  logic [1:0]  broad_type_o;
  logic [1:0]  broad_cpu_id_o;
  logic [31:0] broad_addr_o;
  logic [4:0]  broad_id_o;
  logic [3:0]  broad_done_i;
  logic [3:0]  port_busy_o;
  logic        illegal_cmd_o;

  mesi_isc_broad_arb dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mbus_cmd_i     (mbus_cmd_i),
    .mbus_addr_i    (mbus_addr_i),
    .mbus_ack_o     (mbus_ack_o),
    .broad_valid_o  (broad_valid_o),
    .broad_ready_i  (broad_ready_i),
    .broad_type_o   (broad_type_o),
    .broad_cpu_id_o (broad_cpu_id_o),
    .broad_addr_o   (broad_addr_o),
    .broad_id_o     (broad_id_o),
    .broad_done_i   (broad_done_i),
    .port_busy_o    (port_busy_o),
    .illegal_cmd_o  (illegal_cmd_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  logic [40:0] sb[$];
  logic [40:0] mon_exp;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [40:0] mk(input int t, input int c, input int a, input int id);
    logic [1:0]  tt = 2'(t);
    logic [1:0]  cc = 2'(c);
    logic [31:0] aa = 32'(a);
    logic [4:0]  ii = 5'(id);
    return {tt, cc, aa, ii};
  endfunction

  task automatic set_cmd(input int p, input int c, input int a);
    mbus_cmd_i[p*3 +: 3]    = 3'(c);
    mbus_addr_i[p*32 +: 32] = 32'(a);
  endtask

  task automatic step_ack(input string tag, input logic [3:0] exp);
    @(negedge clk);
    chk(tag, mbus_ack_o, exp);
    @(posedge clk); #1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drain();
    repeat (2) tick();
    chk("sb_drain", sb.size(), 0);
  endtask

  task automatic reset_dut();
    rst_n         = 1'b0;
    mbus_cmd_i    = '0;
    mbus_addr_i   = '0;
    broad_done_i  = '0;
    broad_ready_i = 1'b1;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Output-side monitor: every accepted request must match the queue head.
  always @(negedge clk) begin
    if (rst_n && broad_valid_o && broad_ready_i) begin
      if (sb.size() == 0) chk("sb_unexpected", 1, 0);
      else begin
        mon_exp = sb.pop_front();
        chk("payload", {broad_type_o, broad_cpu_id_o, broad_addr_o, broad_id_o}, mon_exp);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state and a single WR_BROAD
    reset_dut();
    @(negedge clk);
    chk("rst_outs", {mbus_ack_o, broad_valid_o, port_busy_o, illegal_cmd_o}, 0);
    chk("rst_payload", {broad_type_o, broad_cpu_id_o, broad_addr_o, broad_id_o}, 0);
    tick();
    set_cmd(0, 3, 32'h1);
    sb.push_back(mk(1, 0, 1, 0));
    step_ack("t1_ack", 4'b0001);
    set_cmd(0, 0, 0);
    @(negedge clk);
    chk("t1_busy", port_busy_o, 4'b0001);
    chk("t1_valid", broad_valid_o, 1);
    tick();
    broad_done_i = 4'b0001;
    @(negedge clk);
    chk("t1_valid_drop", broad_valid_o, 0);
    tick();
    broad_done_i = 4'b0000;
    @(negedge clk);
    chk("t1_busy_clr", port_busy_o, 4'b0000);
    tick();
    // Stale done colliding with a new grant: grant wins
    broad_done_i = 4'b0001;
    set_cmd(0, 4, 32'h2);
    sb.push_back(mk(2, 0, 2, 1));
    step_ack("t1_stale_ack", 4'b0001);
    broad_done_i = 4'b0000;
    set_cmd(0, 0, 0);
    @(negedge clk);
    chk("t1_stale_busy", port_busy_o, 4'b0001);
    tick();
    broad_done_i = 4'b0010;
    tick();
    broad_done_i = 4'b0000;
    @(negedge clk);
    chk("t1_idle_done", port_busy_o, 4'b0001);
    drain();

    // Three simultaneous RD_BROADs, then pointer position probe
    reset_dut();
    for (int p = 0; p < 3; p++) set_cmd(p, 4, 32'hA0 + p);
    for (int k = 0; k < 3; k++) begin
      sb.push_back(mk(2, k, 32'hA0 + k, k));
      step_ack("t2_ack", 4'(1 << k));
      set_cmd(k, 0, 0);
    end
    @(negedge clk);
    chk("t2_busy", port_busy_o, 4'b0111);
    tick();
    broad_done_i = 4'b0111;
    step_ack("t2_idle", 4'b0000);
    broad_done_i = 4'b0000;
    set_cmd(0, 3, 32'hB0);
    set_cmd(3, 3, 32'hB3);
    sb.push_back(mk(1, 3, 32'hB3, 3));
    step_ack("t2_rr3", 4'b1000);
    set_cmd(3, 0, 0);
    sb.push_back(mk(1, 0, 32'hB0, 4));
    step_ack("t2_rr0", 4'b0001);
    set_cmd(0, 0, 0);
    drain();

    // Busy port skipped, granted after its done
    reset_dut();
    set_cmd(1, 3, 32'h100);
    sb.push_back(mk(1, 1, 32'h100, 0));
    step_ack("t3_p1", 4'b0010);
    set_cmd(1, 0, 0);
    set_cmd(3, 4, 32'h300);
    sb.push_back(mk(2, 3, 32'h300, 1));
    step_ack("t3_p3", 4'b1000);
    set_cmd(3, 0, 0);
    set_cmd(1, 4, 32'h110);
    set_cmd(2, 3, 32'h200);
    sb.push_back(mk(1, 2, 32'h200, 2));
    step_ack("t3_skip_busy", 4'b0100);
    set_cmd(2, 0, 0);
    broad_done_i = 4'b0010;
    step_ack("t3_still_busy", 4'b0000);
    broad_done_i = 4'b0000;
    sb.push_back(mk(2, 1, 32'h110, 3));
    step_ack("t3_after_done", 4'b0010);
    set_cmd(1, 0, 0);
    drain();

    // Output stall for 5 cycles
    reset_dut();
    broad_ready_i = 1'b0;
    set_cmd(0, 3, 32'hA0);
    sb.push_back(mk(1, 0, 32'hA0, 0));
    step_ack("t4_ack0", 4'b0001);
    set_cmd(0, 0, 0);
    set_cmd(3, 4, 32'h3A);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t4_stall_ack", mbus_ack_o, 4'b0000);
      chk("t4_hold", {broad_valid_o, broad_type_o, broad_cpu_id_o, broad_addr_o, broad_id_o},
          {1'b1, mk(1, 0, 32'hA0, 0)});
      tick();
    end
    broad_ready_i = 1'b1;
    sb.push_back(mk(2, 3, 32'h3A, 1));
    step_ack("t4_ack3", 4'b1000);
    set_cmd(3, 0, 0);
    drain();

    // 33 back-to-back grants: id wraps 31 -> 0
    reset_dut();
    for (int k = 0; k < 33; k++) begin
      mbus_cmd_i   = '0;
      set_cmd(k % 4, 3, k);
      broad_done_i = (k > 0) ? 4'(1 << ((k - 1) % 4)) : 4'b0000;
      sb.push_back(mk(1, k % 4, k, k % 32));
      step_ack("t5_ack", 4'(1 << (k % 4)));
    end
    mbus_cmd_i   = '0;
    broad_done_i = 4'b0001;
    tick();
    broad_done_i = 4'b0000;
    drain();

    // Illegal command and asynchronous reset
    reset_dut();
    set_cmd(2, 6, 32'hDEAD);
    step_ack("t6_ack_a", 4'b0000);
    @(negedge clk);
    chk("t6_flags", {illegal_cmd_o, broad_valid_o, port_busy_o}, {1'b1, 1'b0, 4'b0000});
    tick();
    set_cmd(2, 0, 0);
    step_ack("t6_ack_b", 4'b0000);
    @(negedge clk);
    chk("t6_sticky", illegal_cmd_o, 1);
    tick();
    broad_ready_i = 1'b0;
    set_cmd(0, 3, 32'h55);
    sb.push_back(mk(1, 0, 32'h55, 0));
    step_ack("t6_ack0", 4'b0001);
    set_cmd(0, 0, 0);
    @(negedge clk);
    chk("t6_pending", {broad_valid_o, illegal_cmd_o}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_rst", {broad_valid_o, illegal_cmd_o, port_busy_o, mbus_ack_o}, 0);
    sb.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    broad_ready_i = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mesi_isc_broad_arb.md
# mesi_isc_broad_arb

Round-robin arbiter that shares the single broadcast-request path of the MESI intercache coherence controller between four main-bus ports. It accepts WR_BROAD/RD_BROAD commands from each port, enforces at most one outstanding broadcast per port, tags each grant with a rolling broadcast ID, and presents one request at a time to the broadcast queue through a registered valid/ready stage.

## Interface
- NUM_PORTS, 4: number of main-bus requesters; fixed at 4 in this revision.
- PORT_ID_WIDTH, 2: width of the CPU ID field.
- MBUS_CMD_WIDTH, 3: main-bus command width.
- ADDR_WIDTH, 32: address width.
- BROAD_TYPE_WIDTH, 2: broadcast type width.
- BROAD_ID_WIDTH, 5: broadcast ID width.

- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mbus_cmd_i  in  NUM_PORTS*MBUS_CMD_WIDTH  per-port command; port p occupies bits [p*3 +: 3].
- mbus_addr_i  in  NUM_PORTS*ADDR_WIDTH  per-port address.
- mbus_ack_o  out  NUM_PORTS  one-cycle accept pulse per port.
- broad_valid_o  out  1  output request valid.
- broad_ready_i  in  1  broadcast queue can take a request.
- broad_type_o  out  BROAD_TYPE_WIDTH  1 = WR, 2 = RD.
- broad_cpu_id_o  out  PORT_ID_WIDTH  originating port.
- broad_addr_o  out  ADDR_WIDTH  request address.
- broad_id_o  out  BROAD_ID_WIDTH  rolling tag.
- broad_done_i  in  NUM_PORTS  one-cycle pulse: port's broadcast has completed.
- port_busy_o  out  NUM_PORTS  port has an outstanding broadcast.
- illegal_cmd_o  out  1  sticky flag: command 5..7 was seen on any port.

## Operation
- Commands: 0 NOP, 1 WR, 2 RD, 3 WR_BROAD, 4 RD_BROAD. Only commands 3 and 4 are arbitrated. Commands 1 and 2 are ignored here; the local path handles them.
- A port is eligible when its command is 3 or 4 and port_busy_o[p] = 0.
- Load condition: !broad_valid_o || broad_ready_i.
- On the load condition with at least one eligible port:
  - Grant the first eligible port, scanning p = rr_ptr, rr_ptr+1, ... modulo 4.
  - Pulse mbus_ack_o[p] in the same cycle.
  - Register the outputs: type = 1 for cmd 3, 2 for cmd 4; cpu_id = p; addr = that port's address; id = id_cnt.
  - Update registers: rr_ptr <= p+1 (wraps 3 -> 0); id_cnt <= id_cnt+1 (wraps 31 -> 0); set port_busy_o[p].
- On the load condition with no eligible port, broad_valid_o drops to 0 once the current request has been taken.
- broad_done_i[p] clears port_busy_o[p]. If broad_done_i[p] and a new grant to p land in the same cycle, the grant wins. A port cannot be granted while busy, so this arises only for a stale done; it must still be handled.
- broad_done_i for a port that is not busy is ignored.
- Any command 5..7 sets illegal_cmd_o until reset. The command is never acked or granted.
- Requests stay held while unacked. The arbiter never drops or reorders a held request. The requester keeps its command and address stable until mbus_ack_o.

## Timing
- Reset values: every output 0; rr_ptr = 0; id_cnt = 0; all busy bits 0.
- Latency: grant and mbus_ack_o in cycle N; broad_valid_o with its payload in cycle N+1.
- Back-to-back: with broad_ready_i held at 1, one grant per cycle (full throughput).
- Stall: while broad_valid_o && !broad_ready_i, all payload outputs hold stable and no mbus_ack_o is issued.
- Reset asserted mid-operation clears any pending output request immediately and asynchronously. Requesters re-issue after reset.
- port_busy_o rises the cycle after the grant and falls the cycle after broad_done_i.

## Structure
- Shared package mesi_isc_pkg holds:
  - MBUS command codes 0..4;
  - BREQ type codes (NOP 0, WR 1, RD 2);
  - the default widths.
- One sub-module, mesi_isc_rr_pick: combinational 4-way priority picker rotated by rr_ptr. Inputs: the eligible vector and the pointer. Outputs: a one-hot grant and its encoded index.
- The top level holds:
  - the pointer, ID counter and busy bits;
  - the output register stage;
  - the sticky error flag.

## Test plan
- Reset, then port 0 issues cmd 3 at addr 0x1 with broad_ready_i = 1. Required:
  - mbus_ack_o = 0001 in cycle N;
  - cycle N+1: broad_valid_o = 1, type 1, cpu_id 0, addr 0x1, id 0;
  - port_busy_o = 0001.
- Ports 0, 1 and 2 issue cmd 4 simultaneously with ready held high. Required:
  - grants in order 0, 1, 2 on consecutive cycles;
  - ids 0, 1, 2;
  - rr_ptr ends at 3.
- A busy port 1 re-requests while port 2 also requests. Required:
  - port 2 is granted and port 1 gets no ack;
  - after broad_done_i[1], port 1 is granted on the next load condition.
- broad_ready_i = 0 for 5 cycles with a valid request held and port 3 requesting. Required:
  - payload stays stable for all 5 cycles;
  - port 3 gets no ack until ready rises.
- 33 successive grants. Required: broad_id_o runs 0..31 and then wraps back to 0.
- Port 2 drives cmd 6. Required:
  - illegal_cmd_o = 1 and stays 1;
  - no ack or grant for port 2;
  - rst_n low asynchronously clears the flag and broad_valid_o.
